// File: rtl/pwm_pkg.sv
`default_nettype none
/******************************************************************************
 * Module      : pwm_pkg
 * Description : Shared class encodings, FSM states and default thresholds
 *               for the PWM analyzer.
 * Revision    : 1.0
 ******************************************************************************/
package pwm_pkg;

    typedef enum logic [1:0] {
        CLASS_NONE = 2'b00,
        CLASS_LOW  = 2'b01,
        CLASS_MID  = 2'b10,
        CLASS_HIGH = 2'b11
    } pwm_class_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_STORE     = 3'd4
    } pwm_state_e;

    localparam int unsigned C_MAX_COUNTER_VALUE  = 2000;
    localparam int unsigned C_HIGH_COUNTER_VALUE = 1900;
    localparam int unsigned C_LOW_COUNTER_VALUE  = 1100;

    // Equality with either threshold lands in MID.
    function automatic pwm_class_e classify(input int unsigned width,
                                            input int unsigned high_thr,
                                            input int unsigned low_thr);
        if (width > high_thr) begin
            return CLASS_HIGH;
        end else if (width < low_thr) begin
            return CLASS_LOW;
        end else begin
            return CLASS_MID;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
/******************************************************************************
 * Module      : pwm_sync_edge
 * Description : 2-FF synchroniser with rise/fall detect on the synced level.
 * Revision    : 1.0
 ******************************************************************************/
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_measure_sequencer.sv
`default_nettype none
/******************************************************************************
 * Module      : pwm_measure_sequencer
 * Description : Round-robin pulse-width measurement and classification over
 *               NUM_CH PWM inputs sharing one counter pair and classifier.
 * Revision    : 1.0
 ******************************************************************************/
module pwm_measure_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned MAX_COUNTER_VALUE  = C_MAX_COUNTER_VALUE,
    parameter int unsigned HIGH_COUNTER_VALUE = C_HIGH_COUNTER_VALUE,
    parameter int unsigned LOW_COUNTER_VALUE  = C_LOW_COUNTER_VALUE
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic [NUM_CH-1:0]                      pwm_in,
    output logic                                   busy,
    output logic                                   res_valid,
    output logic [$clog2(NUM_CH)-1:0]              res_ch,
    output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] res_width,
    output logic [1:0]                             res_class,
    output logic [2*NUM_CH-1:0]                    class_vec
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(MAX_COUNTER_VALUE + 1);

    localparam logic [CNT_W-1:0] C_W_MAX   = CNT_W'(MAX_COUNTER_VALUE);
    localparam logic [CNT_W-1:0] C_T_LAST  = CNT_W'(MAX_COUNTER_VALUE - 1);
    localparam logic [CH_W-1:0]  C_CH_LAST = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            pwm_sync_edge u_sync_edge (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_pwm  (pwm_in[g]),
                .o_sync (w_sync[g]),
                .o_rise (w_rise[g]),
                .o_fall (w_fall[g])
            );
        end
    endgenerate

    pwm_state_e       r_state;
    pwm_state_e       w_state_nxt;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  w_ch_nxt;
    logic [CNT_W-1:0] r_t;
    logic [CNT_W-1:0] w_t_nxt;
    logic [CNT_W-1:0] r_w;
    logic [CNT_W-1:0] w_w_nxt;

    logic w_sel_sync;
    logic w_sel_rise;
    logic w_sel_fall;

    assign w_sel_sync = w_sync[r_ch];
    assign w_sel_rise = w_rise[r_ch];
    assign w_sel_fall = w_fall[r_ch];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_t     <= '0;
            r_w     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_t     <= w_t_nxt;
            r_w     <= w_w_nxt;
        end
    end

    // Timeout uses >= so an ARM exit on its last cycle still times out in WAIT_RISE.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_t_nxt     = r_t;
        w_w_nxt     = r_w;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_ch_nxt    = '0;
            w_t_nxt     = '0;
            w_w_nxt     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARM;
                    w_ch_nxt    = '0;
                    w_t_nxt     = '0;
                    w_w_nxt     = '0;
                end
                ST_ARM: begin
                    if (!w_sel_sync) begin
                        w_state_nxt = ST_WAIT_RISE;
                        w_t_nxt     = r_t + 1'b1;
                    end else if (r_t >= C_T_LAST) begin
                        w_state_nxt = ST_STORE;
                        w_w_nxt     = C_W_MAX;
                    end else begin
                        w_t_nxt     = r_t + 1'b1;
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_sel_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_w_nxt     = CNT_W'(1);
                    end else if (r_t >= C_T_LAST) begin
                        w_state_nxt = ST_STORE;
                        w_w_nxt     = '0;
                    end else begin
                        w_t_nxt     = r_t + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_sel_fall || (r_w == C_W_MAX)) begin
                        w_state_nxt = ST_STORE;
                    end else if (w_sel_sync) begin
                        w_w_nxt     = r_w + 1'b1;
                    end
                end
                ST_STORE: begin
                    w_state_nxt = ST_ARM;
                    w_ch_nxt    = (r_ch == C_CH_LAST) ? '0 : r_ch + 1'b1;
                    w_t_nxt     = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    pwm_class_e            w_class;
    logic                  r_res_valid;
    logic [CH_W-1:0]       r_res_ch;
    logic [CNT_W-1:0]      r_res_width;
    pwm_class_e            r_res_class;
    logic [2*NUM_CH-1:0]   r_class_vec;

    assign w_class = classify(32'(r_w), HIGH_COUNTER_VALUE, LOW_COUNTER_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_width <= '0;
            r_res_class <= CLASS_NONE;
            r_class_vec <= '0;
        end else if ((r_state == ST_STORE) && en) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= r_ch;
            r_res_width <= r_w;
            r_res_class <= w_class;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (r_ch == CH_W'(c)) begin
                    r_class_vec[2*c +: 2] <= w_class;
                end
            end
        end else begin
            r_res_valid <= 1'b0;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_width = r_res_width;
    assign res_class = r_res_class;
    assign class_vec = r_class_vec;

endmodule
`default_nettype wire

// File: doc/pwm_measure_sequencer.md
# pwm_measure_sequencer

Round-robin measurement controller for the PWM analyzer: it shares one pulse-width counter and one threshold classifier across `NUM_CH` PWM inputs. For each channel in turn it arms, waits for a rising edge, measures the high time in clock cycles and classifies it as LOW, MID or HIGH against the analyzer thresholds. It publishes a one-cycle result strobe and a per-channel status vector. It sits between the synchronised `ui_in` PWM pins and the 7-segment display driver, and is gated by the user enable switch.

## Interface
- `NUM_CH`, 4, number of PWM inputs scheduled (2..8)
- `MAX_COUNTER_VALUE`, 2000, per-phase cycle limit and width saturation value
- `HIGH_COUNTER_VALUE`, 1900, width strictly above this value classifies as HIGH
- `LOW_COUNTER_VALUE`, 1100, width strictly below this value classifies as LOW
- `clk`  in  1  system clock, 1 MHz nominal
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  sequencer enable (user switch, already synchronous)
- `pwm_in`  in  NUM_CH  raw asynchronous PWM inputs
- `busy`  out  1  high whenever the FSM is not IDLE
- `res_valid`  out  1  one-cycle result strobe
- `res_ch`  out  $clog2(NUM_CH)  channel index of the current result
- `res_width`  out  CNT_W  measured high width, CNT_W = $clog2(MAX_COUNTER_VALUE+1)
- `res_class`  out  2  class of the current result
- `class_vec`  out  2*NUM_CH  last class per channel; channel c occupies bits [2c+1:2c]

## Operation
- Reset values: every output, the channel pointer, both counters and the synchronisers are 0. The FSM is in IDLE.
- Class encoding: 00 = never measured (reset value only), 01 = LOW, 10 = MID, 11 = HIGH.
- Classification: width > HIGH gives 11; width < LOW gives 01; otherwise 10. Equality with either threshold gives MID.
- Each `pwm_in` bit passes through a 2-FF synchroniser. Edge detection runs on the synchronised value only.
- FSM states:
  - IDLE: when `en`=1, go to ARM with channel 0 and t=0.
  - ARM: wait for the synchronised input to be low, then go to WAIT_RISE. If t reaches MAX-1 first, the channel is stuck high: go to STORE with w=MAX.
  - WAIT_RISE: on a synchronised rising edge, go to MEASURE with w=1. If t reaches MAX-1 first, the channel is stuck low: go to STORE with w=0.
  - MEASURE: increment w each cycle the input stays high. A synchronised falling edge goes to STORE with w unchanged. If w reaches MAX, go to STORE with w=MAX.
  - STORE: register the result and class, then move to ARM with the next channel (NUM_CH-1 wraps to 0) and t=0.
- Timeout counter t runs in ARM and WAIT_RISE only and continues across the ARM to WAIT_RISE transition.
- Simultaneous events:
  - A falling edge on the same cycle w reaches MAX: the falling edge wins and w=MAX is stored.
  - A rising edge on the timeout cycle: the edge wins and the FSM enters MEASURE.
- Disabling: `en`=0 in any state moves the FSM to IDLE on the next edge, with no STORE and no `res_valid`. The channel pointer resets to 0 and `class_vec` is retained.
- Asynchronous reset mid-operation clears everything, including `class_vec`.

## Timing
- Input to FSM latency is 2 cycles (synchroniser). A pulse of N synchronised high cycles yields `res_width`=N.
- STORE lasts one cycle. `res_valid`, `res_ch`, `res_width`, `res_class` and the `class_vec` slice update on the clock edge leaving STORE.
- `res_valid` is high for exactly one cycle, coinciding with the first ARM cycle of the next channel. The `res_*` outputs hold their value until the next STORE.
- Worst-case scan time per channel is 2*MAX + 2 cycles.
- `busy` is combinational from the state register (state != IDLE).

## Structure
- Shared package `pwm_pkg`: class encodings (`CLASS_NONE`/`LOW`/`MID`/`HIGH`), the FSM state enum, and the default threshold constants reused by the analyzer top.
- Sub-module `pwm_sync_edge`: 2-FF synchroniser plus rise/fall detect, one instance per channel.
- The counters, the classifier compare and the FSM stay in `pwm_measure_sequencer`.

## Test plan
- Defaults, `en`=1, ch0 pulse of 500 high cycles -> `res_valid` with ch=0, width=500, class=01; `class_vec`[1:0]=01.
- Boundaries, pulses of 1099 / 1100 / 1900 / 1901 cycles on ch1 over successive scans -> classes 01 / 10 / 10 / 11.
- ch2 held high -> width=2000, class=11 after exactly 2000 ARM cycles. ch3 held low -> width=0, class=01. Then ch0 is scanned next (wrap).
- `en` dropped 300 cycles into MEASURE on ch1 -> no `res_valid`, `busy`=0 next cycle, `class_vec` unchanged. Re-enabling restarts at ch0.
- Pulse of ≥2000 high cycles on ch0 -> w saturates; STORE reports width=2000, class=11, with the falling edge and saturation coinciding handled once.
- `rst_n` asserted mid-MEASURE -> all outputs 0 immediately (asynchronous). After release with `en`=1, measurement starts at ch0.
